// File: rtl/risc8_pkg.sv
// ============================================================================
// risc8_pkg : shared types and constants for the 8-bit RISC core
// Rev 1.0
// ============================================================================
`default_nettype none

package risc8_pkg;

  typedef logic [7:0] word_t;

  localparam int FETCH_MAX_IMM = 3;
  localparam int IMM_WIDTH     = 8 * FETCH_MAX_IMM;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_VALID = 2'd3
  } e_fetch_state;

endpackage

`default_nettype wire

// File: rtl/risc8_fetch.sv
// ============================================================================
// risc8_fetch : opcode + immediate fetch unit feeding the instruction decoder
// Rev 1.0
// ============================================================================
`default_nettype none

module risc8_fetch
  import risc8_pkg::*;
#(
  parameter int                  PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [PC_WIDTH-1:0]  pm_addr,
  output logic                 pm_rd,
  input  word_t                pm_data,
  output word_t                instr,
  input  logic [1:0]           isize,
  output logic [IMM_WIDTH-1:0] imm,
  output logic                 valid,
  input  logic                 ready,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [PC_WIDTH-1:0]  pc_next,
  input  logic                 redirect,
  input  logic [PC_WIDTH-1:0]  redirect_pc
);

  e_fetch_state        state;
  logic [PC_WIDTH-1:0] fpc;
  logic [2:0]          cnt;
  logic                done;

  // isize is only trusted once the opcode has been latched (cnt >= 1).
  assign done    = (cnt != 3'd0) && (cnt > {1'b0, isize});

  assign pm_rd   = (state == S_FETCH) && !done;
  assign pm_addr = fpc;
  assign pc_next = fpc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      fpc   <= RESET_VECTOR;
      cnt   <= 3'd0;
      instr <= '0;
      imm   <= '0;
      pc    <= RESET_VECTOR;
      valid <= 1'b0;
    end else if (redirect && (state != S_IDLE)) begin
      // Any read in flight is abandoned; architectural outputs stay untouched.
      fpc   <= redirect_pc;
      cnt   <= 3'd0;
      state <= S_FETCH;
      valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_FETCH;
        end
        S_FETCH: begin
          if (done) begin
            state <= S_VALID;
            valid <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 3'd0) begin
            instr <= pm_data;
            imm   <= '0;
            pc    <= fpc;
          end else begin
            case (cnt)
              3'd1:    imm[7:0]   <= pm_data;
              3'd2:    imm[15:8]  <= pm_data;
              3'd3:    imm[23:16] <= pm_data;
              default: ;
            endcase
          end
          fpc   <= fpc + PC_WIDTH'(1);
          cnt   <= cnt + 3'd1;
          state <= S_FETCH;
        end
        S_VALID: begin
          if (ready) begin
            cnt   <= 3'd0;
            state <= S_FETCH;
            valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_risc8_fetch.sv
// ============================================================================
// tb_risc8_fetch : scoreboard bench for risc8_fetch with a behavioural ROM
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_risc8_fetch;
  import risc8_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] pm_addr;
  logic        pm_rd;
  word_t       pm_data;
  word_t       instr;
  logic [1:0]  isize;
  logic [23:0] imm;
  logic        valid;
  logic        ready;
  logic [15:0] pc;
  logic [15:0] pc_next;
  logic        redirect;
  logic [15:0] redirect_pc;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0]  op;
    logic [23:0] imm;
    logic [15:0] pc;
    logic [15:0] pcn;
  } exp_t;

  exp_t sb[$];
  exp_t got;

  logic [7:0] rom [0:65535];

  risc8_fetch #(.PC_WIDTH(16), .RESET_VECTOR(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pm_addr     (pm_addr),
    .pm_rd       (pm_rd),
    .pm_data     (pm_data),
    .instr       (instr),
    .isize       (isize),
    .imm         (imm),
    .valid       (valid),
    .ready       (ready),
    .pc          (pc),
    .pc_next     (pc_next),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decoder stand-in: immediate count lives in the opcode's top two bits.
  assign isize = instr[7:6];

  always @(posedge clk) if (pm_rd) pm_data <= rom[pm_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_instr: got instr 'h%0h pc 'h%0h expected none", instr, pc);
      end else begin
        got = sb.pop_front();
        chk("sb_instr",   {24'h0, instr}, {24'h0, got.op});
        chk("sb_imm",     {8'h0, imm},    {8'h0, got.imm});
        chk("sb_pc",      {16'h0, pc},    {16'h0, got.pc});
        chk("sb_pc_next", {16'h0, pc_next}, {16'h0, got.pcn});
      end
    end
  end

  initial begin
    rst_n = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
    rom[16'h0000] = 8'h01; rom[16'h0001] = 8'h02; rom[16'h0002] = 8'hC0;
    rom[16'h0010] = 8'hC5; rom[16'h0011] = 8'hAA; rom[16'h0012] = 8'hBB; rom[16'h0013] = 8'hCC;
    rom[16'h0030] = 8'h83; rom[16'h0031] = 8'h11; rom[16'h0032] = 8'h22;
    rom[16'h0040] = 8'h82; rom[16'h0041] = 8'h5A; rom[16'h0042] = 8'hA5;
    rom[16'hFFFF] = 8'h80;

    step(); step();
    chk("rst_valid", valid, 0);
    chk("rst_pm_rd", pm_rd, 0);
    chk("rst_instr", instr, 0);
    chk("rst_imm",   imm, 0);
    chk("rst_pc",    pc, 0);

    // Reset release: cycle 0 is the idle cycle.
    rst_n = 1'b1;
    sb.push_back({8'h01, 24'h000000, 16'h0000, 16'h0001});
    chk("idle_pm_rd", pm_rd, 0);
    step();
    chk("c1_pm_rd",   pm_rd, 1);
    chk("c1_pm_addr", pm_addr, 16'h0000);
    step(); chk("c2_valid", valid, 0);
    step(); chk("c3_valid", valid, 0);
    step(); chk("c4_valid", valid, 1);

    // Back-pressure: everything frozen, no reads.
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid",   valid, 1);
      chk("hold_pm_rd",   pm_rd, 0);
      chk("hold_instr",   instr, 8'h01);
      chk("hold_imm",     imm, 0);
      chk("hold_pc",      pc, 16'h0000);
      chk("hold_pc_next", pc_next, 16'h0001);
      step();
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("next_pm_rd",   pm_rd, 1);
    chk("next_pm_addr", pm_addr, 16'h0001);

    // Jump to 0x0010 while valid=0: partial fetch dropped.
    redirect = 1'b1; redirect_pc = 16'h0010;
    step();
    redirect = 1'b0;
    sb.push_back({8'hC5, 24'hCCBBAA, 16'h0010, 16'h0014});
    chk("jmp_pm_addr", pm_addr, 16'h0010);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("jmp_not_valid", valid, 0);
    end
    step();
    chk("jmp_valid9", valid, 1);
    ready = 1'b1;
    step();
    ready = 1'b0;

    // Redirect to 0x30, then redirect again during the 2nd-immediate read.
    redirect = 1'b1; redirect_pc = 16'h0030;
    step();
    redirect = 1'b0;
    step(); step(); step(); step(); step();
    redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    chk("disc_instr",   instr, 8'h83);
    chk("disc_imm",     imm, 24'h000011);
    chk("disc_pc",      pc, 16'h0030);
    chk("disc_valid",   valid, 0);
    chk("disc_pm_addr", pm_addr, 16'h0040);
    sb.push_back({8'h82, 24'h00A55A, 16'h0040, 16'h0043});
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("r40_not_valid", valid, 0);
    end
    step();
    chk("r40_valid7", valid, 1);

    // Accept and redirect in the same cycle, landing on the wrap boundary.
    ready = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFF;
    step();
    ready = 1'b0; redirect = 1'b0;
    sb.push_back({8'h80, 24'h000201, 16'hFFFF, 16'h0002});
    chk("wrap_rd0",   pm_rd, 1);
    chk("wrap_addr0", pm_addr, 16'hFFFF);
    step(); step();
    chk("wrap_rd1",   pm_rd, 1);
    chk("wrap_addr1", pm_addr, 16'h0000);
    step(); step();
    chk("wrap_rd2",   pm_rd, 1);
    chk("wrap_addr2", pm_addr, 16'h0001);
    step(); step();
    chk("wrap_rd_done", pm_rd, 0);
    step();
    chk("wrap_valid", valid, 1);
    ready = 1'b1;
    step();
    ready = 1'b0;

    // Opcode 0xC0 at 0x0002; reset while the first immediate read is issued.
    step(); step();
    chk("prerst_pm_rd", pm_rd, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_pm_rd", pm_rd, 0);
    chk("arst_valid", valid, 0);
    chk("arst_instr", instr, 0);
    chk("arst_pc",    pc, 0);
    step(); step();
    rst_n = 1'b1;
    sb.push_back({8'h01, 24'h000000, 16'h0000, 16'h0001});
    step();
    chk("rerst_pm_rd",   pm_rd, 1);
    chk("rerst_pm_addr", pm_addr, 16'h0000);
    step(); step(); step();
    chk("rerst_valid", valid, 1);
    ready = 1'b1;
    step();
    ready = 1'b0;
    step();
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
